// File: rtl/wait_state_memory.sv
// Unified instruction/data memory with per-port programmable wait states.
// Fetch port reads the text ROM; load/store port reaches user, kernel and debug RAMs.

module wsm_port_ctl #(
  parameter int LAT = 0,
  parameter int KW  = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          err,
  input  logic [KW-1:0] key,
  output logic          busy,
  output logic          done
);
  localparam logic [3:0] LAT_C = 4'(LAT);

  logic [3:0]    cnt, cnt_eff;
  logic [KW-1:0] cap;

  // A request that differs from the one captured last edge counts as a fresh
  // access this very cycle, so it always sees the full LAT wait.
  always_comb begin
    cnt_eff = (key != cap) ? 4'd0 : cnt;
    busy    = reset_n & req & ~err & (cnt_eff < LAT_C);
    done    = reset_n & req & ~err & ~busy;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      cap <= '0;
    end else begin
      cnt <= busy ? cnt_eff + 4'd1 : 4'd0;
      if (req) cap <= key;
    end
  end
endmodule

module wait_state_memory #(
  parameter int USER_AW  = 12,
  parameter int KERN_AW  = 10,
  parameter int DBG_AW   = 3,
  parameter int TEXT_AW  = 20,
  parameter int DATA_LAT = 2,
  parameter int INS_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ins_req,
  input  logic [31:0] ins_addr,
  output logic [31:0] ins_dout,
  output logic        ins_busy,
  output logic        ins_err,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_din,
  output logic [31:0] data_dout,
  output logic        data_busy,
  output logic        data_err
);
  localparam logic [31:0] USER_B = 32'h1000_0000;
  localparam logic [31:0] TEXT_B = 32'h4040_0000;
  localparam logic [31:0] KERN_B = 32'hA000_0000;
  localparam logic [31:0] DBG_B  = 32'hFFFF_0000;

  // Region ends are 33 bits so the top region may end exactly at 2^32.
  localparam logic [32:0] USER_E = {1'b0, USER_B} + (33'd4 << USER_AW);
  localparam logic [32:0] TEXT_E = {1'b0, TEXT_B} + (33'd4 << TEXT_AW);
  localparam logic [32:0] KERN_E = {1'b0, KERN_B} + (33'd4 << KERN_AW);
  localparam logic [32:0] DBG_E  = {1'b0, DBG_B}  + (33'd4 << DBG_AW);

  if (USER_E > {1'b0, TEXT_B} || TEXT_E > {1'b0, KERN_B} ||
      KERN_E > {1'b0, DBG_B}  || DBG_E  > 33'h1_0000_0000 ||
      DATA_LAT < 0 || DATA_LAT > 15 || INS_LAT < 0 || INS_LAT > 15) begin : g_bad_cfg
    $error("wait_state_memory: overlapping region map or latency outside 0..15");
  end

  function automatic logic in_rgn(input logic [31:0] a, input logic [31:0] base,
                                  input logic [32:0] lim);
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < lim);
  endfunction

  logic [31:0] user_ram [2**USER_AW];
  logic [31:0] kern_ram [2**KERN_AW];
  logic [31:0] dbg_ram  [2**DBG_AW];
  logic [31:0] text_rom [2**TEXT_AW];

  // ---- data port decode ----
  logic               user_hit, kern_hit, dbg_hit, data_bad, data_done;
  logic [USER_AW-1:0] user_off;
  logic [KERN_AW-1:0] kern_off;
  logic [DBG_AW-1:0]  dbg_off;
  logic [31:0]        data_rd;

  always_comb begin
    user_hit = in_rgn(data_addr, USER_B, USER_E);
    kern_hit = in_rgn(data_addr, KERN_B, KERN_E);
    dbg_hit  = in_rgn(data_addr, DBG_B,  DBG_E);
    user_off = USER_AW'((data_addr - USER_B) >> 2);
    kern_off = KERN_AW'((data_addr - KERN_B) >> 2);
    dbg_off  = DBG_AW'((data_addr - DBG_B) >> 2);
    data_bad = data_req & (~(user_hit | kern_hit | dbg_hit) | (data_addr[1:0] != 2'b00));
    data_rd  = '0;
    if (user_hit)      data_rd = user_ram[user_off];
    else if (kern_hit) data_rd = kern_ram[kern_off];
    else if (dbg_hit)  data_rd = dbg_ram[dbg_off];
  end

  wsm_port_ctl #(.LAT(DATA_LAT), .KW(37)) u_data_ctl (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (data_req),
    .err     (data_bad),
    .key     ({data_addr, data_write, data_be}),
    .busy    (data_busy),
    .done    (data_done)
  );

  assign data_err  = reset_n & data_bad;
  assign data_dout = (data_done && !data_write) ? data_rd : '0;

  // done already excludes reset and errored accesses, so it gates the write.
  always_ff @(posedge clk) begin
    if (data_done && data_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be[b]) begin
          if (user_hit)      user_ram[user_off][8*b +: 8] <= data_din[8*b +: 8];
          else if (kern_hit) kern_ram[kern_off][8*b +: 8] <= data_din[8*b +: 8];
          else if (dbg_hit)  dbg_ram[dbg_off][8*b +: 8]   <= data_din[8*b +: 8];
        end
      end
    end
  end

  // ---- instruction port ----
  logic               ins_hit, ins_bad, ins_done;
  logic [TEXT_AW-1:0] ins_off;

  always_comb begin
    ins_hit = in_rgn(ins_addr, TEXT_B, TEXT_E);
    ins_off = TEXT_AW'((ins_addr - TEXT_B) >> 2);
    ins_bad = ins_req & (~ins_hit | (ins_addr[1:0] != 2'b00));
  end

  wsm_port_ctl #(.LAT(INS_LAT), .KW(32)) u_ins_ctl (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (ins_req),
    .err     (ins_bad),
    .key     (ins_addr),
    .busy    (ins_busy),
    .done    (ins_done)
  );

  assign ins_err  = reset_n & ins_bad;
  assign ins_dout = ins_done ? text_rom[ins_off] : '0;
endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory with default parameters (DATA_LAT=2, INS_LAT=1).
module tb_wait_state_memory;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ins_req;
  logic [31:0] ins_addr;
  logic [31:0] ins_dout;
  logic        ins_busy, ins_err;
  logic        data_req, data_write;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_din, data_dout;
  logic        data_busy, data_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wait_state_memory dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ins_req    (ins_req),
    .ins_addr   (ins_addr),
    .ins_dout   (ins_dout),
    .ins_busy   (ins_busy),
    .ins_err    (ins_err),
    .data_req   (data_req),
    .data_write (data_write),
    .data_be    (data_be),
    .data_addr  (data_addr),
    .data_din   (data_din),
    .data_dout  (data_dout),
    .data_busy  (data_busy),
    .data_err   (data_err)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] din;
    logic        err;
    int          busy;
    logic [31:0] dout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Holds the request until completion, counting busy cycles (bounded).
  task automatic data_access(input string nm, input vec_t v);
    int nb;
    @(posedge clk); #1;
    data_req = 1'b1; data_write = v.wr; data_be = v.be; data_addr = v.addr; data_din = v.din;
    nb = 0;
    @(negedge clk);
    while (data_busy === 1'b1 && nb < 20) begin
      chk({nm, " dout_while_busy"}, data_dout, 32'h0);
      nb++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, nb, v.busy);
    chk({nm, " err"}, {31'b0, data_err}, {31'b0, v.err});
    chk({nm, " dout"}, data_dout, v.dout);
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic ins_fetch(input string nm, input logic [31:0] a, input logic e,
                           input int bz, input logic [31:0] d);
    int nb;
    @(posedge clk); #1;
    ins_req = 1'b1; ins_addr = a;
    nb = 0;
    @(negedge clk);
    while (ins_busy === 1'b1 && nb < 20) begin
      chk({nm, " dout_while_busy"}, ins_dout, 32'h0);
      nb++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, nb, bz);
    chk({nm, " err"}, {31'b0, ins_err}, {31'b0, e});
    chk({nm, " dout"}, ins_dout, d);
    @(posedge clk); #1;
    ins_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];

    tbl.push_back(vec_t'{1'b1, 4'hF,    32'h1000_0010, 32'hDEADBEEF, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h1000_0010, 32'h0,        1'b0, 2, 32'hDEADBEEF});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'hA000_0004, 32'h11223344, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b1, 4'b0101, 32'hA000_0004, 32'hAABBCCDD, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'hA000_0004, 32'h0,        1'b0, 2, 32'h11BB33DD});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'h1000_0000, 32'h12345678, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'h1000_0004, 32'h55AA55AA, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'hFFFF_0008, 32'h11111111, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h2000_0000, 32'h0,        1'b1, 0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'hFFFF_0020, 32'h0,        1'b1, 0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'h1000_0002, 32'hCAFEBABE, 1'b1, 0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h1000_0000, 32'h0,        1'b0, 2, 32'h12345678});
    tbl.push_back(vec_t'{1'b1, 4'h0,    32'h1000_0000, 32'hFFFFFFFF, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h1000_0000, 32'h0,        1'b0, 2, 32'h12345678});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'h1000_3FFC, 32'h0F0F0F0F, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h1000_3FFC, 32'h0,        1'b0, 2, 32'h0F0F0F0F});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h1000_4000, 32'h0,        1'b1, 0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'hA000_1000, 32'h0,        1'b1, 0, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'hA000_0005, 32'h0,        1'b1, 0, 32'h0});
    tbl.push_back(vec_t'{1'b1, 4'hF,    32'hFFFF_001C, 32'h0BADF00D, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'hFFFF_001C, 32'h0,        1'b0, 2, 32'h0BADF00D});
    tbl.push_back(vec_t'{1'b1, 4'b1100, 32'h1000_0010, 32'h01234567, 1'b0, 2, 32'h0});
    tbl.push_back(vec_t'{1'b0, 4'hF,    32'h1000_0010, 32'h0,        1'b0, 2, 32'h0123BEEF});

    dut.text_rom[2]        = 32'hCAFE0002;
    dut.text_rom[20'hFFFFF] = 32'h7E570FFF;

    // Reset with requests pending: every output must stay quiet.
    reset_n = 1'b0;
    ins_req = 1'b1; ins_addr = 32'h4040_0008;
    data_req = 1'b1; data_write = 1'b0; data_be = 4'hF;
    data_addr = 32'h1000_0010; data_din = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst data_busy", {31'b0, data_busy}, 32'h0);
    chk("rst data_err",  {31'b0, data_err},  32'h0);
    chk("rst data_dout", data_dout, 32'h0);
    chk("rst ins_busy",  {31'b0, ins_busy},  32'h0);
    chk("rst ins_err",   {31'b0, ins_err},   32'h0);
    chk("rst ins_dout",  ins_dout, 32'h0);
    data_addr = 32'h2000_0001; ins_addr = 32'h0000_0000;
    #1;
    chk("rst bad data_err", {31'b0, data_err}, 32'h0);
    chk("rst bad ins_err",  {31'b0, ins_err},  32'h0);
    @(posedge clk); #1;
    data_req = 1'b0; ins_req = 1'b0; reset_n = 1'b1;

    foreach (tbl[i]) data_access($sformatf("vec%0d", i), tbl[i]);

    ins_fetch("fetch misaligned", 32'h4040_0002, 1'b1, 0, 32'h0);
    ins_fetch("fetch past end",   32'h4080_0000, 1'b1, 0, 32'h0);
    ins_fetch("fetch last word",  32'h407F_FFFC, 1'b0, 1, 32'h7E570FFF);

    // Concurrent fetch (LAT 1) and load (LAT 2), then a back-to-back load.
    @(posedge clk); #1;
    ins_req = 1'b1; ins_addr = 32'h4040_0008;
    data_req = 1'b1; data_write = 1'b0; data_be = 4'hF; data_addr = 32'h1000_0010;
    @(negedge clk);
    chk("par c0 ins_busy",  {31'b0, ins_busy},  32'h1);
    chk("par c0 data_busy", {31'b0, data_busy}, 32'h1);
    chk("par c0 ins_dout",  ins_dout, 32'h0);
    @(negedge clk);
    chk("par c1 ins_busy",  {31'b0, ins_busy},  32'h0);
    chk("par c1 ins_dout",  ins_dout, 32'hCAFE0002);
    chk("par c1 data_busy", {31'b0, data_busy}, 32'h1);
    chk("par c1 data_dout", data_dout, 32'h0);
    @(posedge clk); #1;
    ins_req = 1'b0;
    @(negedge clk);
    chk("par c2 data_busy", {31'b0, data_busy}, 32'h0);
    chk("par c2 data_dout", data_dout, 32'h0123BEEF);
    chk("par c2 ins_dout",  ins_dout, 32'h0);
    @(negedge clk);
    chk("b2b c3 data_busy", {31'b0, data_busy}, 32'h1);
    chk("b2b c3 data_dout", data_dout, 32'h0);
    @(negedge clk);
    chk("b2b c4 data_busy", {31'b0, data_busy}, 32'h1);
    @(negedge clk);
    chk("b2b c5 data_busy", {31'b0, data_busy}, 32'h0);
    chk("b2b c5 data_dout", data_dout, 32'h0123BEEF);
    @(posedge clk); #1;
    data_req = 1'b0;

    // Address changes after one busy cycle: the wait restarts.
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = 32'h1000_0000;
    @(negedge clk);
    chk("chg c0 busy", {31'b0, data_busy}, 32'h1);
    @(posedge clk); #1;
    data_addr = 32'h1000_0004;
    @(negedge clk);
    chk("chg c1 busy", {31'b0, data_busy}, 32'h1);
    @(negedge clk);
    chk("chg c2 busy", {31'b0, data_busy}, 32'h1);
    chk("chg c2 dout", data_dout, 32'h0);
    @(negedge clk);
    chk("chg c3 busy", {31'b0, data_busy}, 32'h0);
    chk("chg c3 dout", data_dout, 32'h55AA55AA);
    @(posedge clk); #1;
    data_req = 1'b0;

    // Reset mid-store, request dropped during reset: no write may land.
    @(posedge clk); #1;
    data_req = 1'b1; data_write = 1'b1; data_be = 4'hF;
    data_addr = 32'hFFFF_0008; data_din = 32'h99999999;
    @(negedge clk);
    chk("rst1 c0 busy", {31'b0, data_busy}, 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst1 busy in reset", {31'b0, data_busy}, 32'h0);
    chk("rst1 err in reset",  {31'b0, data_err},  32'h0);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    data_access("rst1 reread", vec_t'{1'b0, 4'hF, 32'hFFFF_0008, 32'h0, 1'b0, 2, 32'h11111111});

    // Reset mid-store with the request held: full wait after release, then write.
    @(posedge clk); #1;
    data_req = 1'b1; data_write = 1'b1; data_be = 4'hF;
    data_addr = 32'hFFFF_0008; data_din = 32'h99999999;
    @(negedge clk);
    chk("rst2 c0 busy", {31'b0, data_busy}, 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2 busy in reset", {31'b0, data_busy}, 32'h0);
    @(negedge clk);
    chk("rst2 dout in reset", data_dout, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst2 r0 busy", {31'b0, data_busy}, 32'h1);
    @(negedge clk);
    chk("rst2 r1 busy", {31'b0, data_busy}, 32'h1);
    @(negedge clk);
    chk("rst2 r2 busy", {31'b0, data_busy}, 32'h0);
    @(posedge clk); #1;
    data_req = 1'b0;
    data_access("rst2 reread", vec_t'{1'b0, 4'hF, 32'hFFFF_0008, 32'h0, 1'b0, 2, 32'h99999999});
    data_access("kern after reset", vec_t'{1'b0, 4'hF, 32'hA000_0004, 32'h0, 1'b0, 2, 32'h11BB33DD});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wait_state_memory.md
Name: wait_state_memory

Overview:
- Next-generation unified memory block for the MIPS core, serving the instruction fetch port and the load/store port.
- Takes physical addresses; virtual-to-physical mapping stays upstream.
- Adds over the current block: parametrised region sizes, per-port programmable wait states driving a real busy handshake, byte-enable writes, an unmapped-address error flag, and deterministic (non-X) read data.

Parameters:
- USER_AW, 12, log2 word count of user data RAM at base 32'h1000_0000
- KERN_AW, 10, log2 word count of kernel data RAM at base 32'hA000_0000
- DBG_AW, 3, log2 word count of debug argument RAM at base 32'hFFFF_0000
- TEXT_AW, 20, log2 word count of instruction ROM at base 32'h4040_0000
- DATA_LAT, 2, wait states per data access (0..15)
- INS_LAT, 1, wait states per instruction fetch (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous reset, active low
- ins_req  in  1  fetch request, held until completion
- ins_addr  in  32  fetch physical byte address
- ins_dout  out  32  fetched word
- ins_busy  out  1  fetch not yet complete
- ins_err  out  1  fetch address unmapped or misaligned
- data_req  in  1  load/store request, held until completion
- data_write  in  1  1 = store, 0 = load
- data_be  in  4  byte enables for stores, bit i = bits [8i+7:8i]
- data_addr  in  32  data physical byte address
- data_din  in  32  store data
- data_dout  out  32  load data
- data_busy  out  1  data access not yet complete
- data_err  out  1  data address unmapped or misaligned

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on reset_n.
- Two independent port engines, identical except LAT, region map and write capability. No arbitration; ports never stall each other.
- Per-port counter cnt (4 bits) and captured request (addr, write, be, din).
  - cnt clears when req=0, on completion, on reset, or when held addr/write/be differ from captured values. A differing request restarts the wait.
  - Otherwise cnt increments while req=1 and busy=1.
- busy = req & ~err & (cnt < LAT), combinational. With LAT=0, busy never asserts and the access completes in the request cycle.
- Completion cycle: req=1 and busy=0.
  - Loads/fetches: dout = addressed word, valid combinationally in that cycle only.
  - Stores: addressed word updated at the closing edge, only for bytes with be=1. be=0000 is a legal no-op.
- dout = 0 in every non-completion cycle, including a store's completion cycle.
- Data decode, with word offset = (addr - base) >> 2:
  - user: 32'h1000_0000 <= addr < base + 4*2^USER_AW
  - kernel: 32'hA000_0000 <= addr < base + 4*2^KERN_AW
  - debug: 32'hFFFF_0000 <= addr < base + 4*2^DBG_AW
- Instruction decode: 32'h4040_0000 <= addr < base + 4*2^TEXT_AW. ROM, read-only, preloaded by an existing file-based init.
- Error conditions:
  - err = req & (no region hit, or addr[1:0] != 0). Combinational, with busy=0 and dout=0.
  - A store that errors writes nothing. The access counts as complete and cnt clears.
- Region overlap is impossible with the defaults. Elaboration fails if a region end exceeds the next base.
- Reset (reset_n=0 at an edge):
  - cnt=0, captured request cleared, no write performed that edge.
  - While reset_n=0: busy=0, err=0, dout=0 on both ports.
  - RAM contents are preserved.
  - Reset in mid-wait aborts the access. After release, a still-held req restarts a full LAT wait.
- Back-to-back: a new req held high in the cycle after completion starts at cnt=0 and waits the full LAT again.

Test Plan:
- Reset, then data store addr=32'h1000_0010, din=32'hDEADBEEF, be=4'hF, DATA_LAT=2 -> data_busy=1 for 2 cycles, 0 in cycle 3. Then load same addr -> data_dout=32'hDEADBEEF on its completion cycle, 0 while busy.
- Byte enables: preload 32'h11223344 at kernel 32'hA000_0004, store din=32'hAABBCCDD with be=4'b0101 -> load returns 32'h11BB33DD.
- Errors: load 32'h2000_0000, load 32'hFFFF_0020, store 32'h1000_0002 -> err=1, busy=0, dout=0 same cycle. Re-read of 32'h1000_0000 shows unchanged contents.
- Fetch with INS_LAT=1 at 32'h4040_0008 -> ins_busy=1 one cycle, then ROM word 2. Simultaneous data load with DATA_LAT=2 completes one cycle later, independently.
- Change data_addr from 32'h1000_0000 to 32'h1000_0004 after 1 busy cycle -> wait restarts, busy 2 more cycles, returns word at 32'h1000_0004.
- Assert reset_n=0 during a store wait at 32'hFFFF_0008 -> no write occurs. After release, the held store takes the full 2 cycles and then writes.
